// File: rtl/fetch_pkg.sv
// Shared defaults and the prefetch buffer entry layout for the fetch unit.
package fetch_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and full/empty flags.
// Head data is read combinationally from registered storage.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  // Popping an empty FIFO is ignored; a full FIFO still accepts a push when it pops in the same cycle.
  assign pop_en    = pop && !empty;
  assign push_en   = push && (!full || pop_en);

  // Next-state for storage, pointers and occupancy; flush wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Callers size their traffic so a push never lands on a full FIFO without a pop.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) assert (!(push && full && !pop_en));
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch with pipelined memory requests, a prefetch buffer to
// decode, branch redirect with flush, and discard of stale in-flight responses.
module fetch_prefetch_unit import fetch_pkg::*; #(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              DEPTH    = 4,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr
);

  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam int              UW         = CW + 1;
  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(PC_STEP) - XLEN'(1));

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic              started_q, started_d;
  logic [CW-1:0]     pf_count, outstanding;
  logic [UW-1:0]     credit_used;
  logic              req_fire, rsp_drop, pf_push, pf_pop;
  logic [2*XLEN-1:0] pf_head;
  logic [XLEN-1:0]   rsp_pc;
  logic              pf_full, pf_empty, rq_full, rq_empty;
  logic              unused_flags;

  // Every in-flight request owns a buffer slot, so the prefetch FIFO can never overflow.
  // Requests are held off until the first edge after reset release.
  assign credit_used   = UW'(pf_count) + UW'(outstanding);
  assign mem_req_valid = started_q && !redirect_valid && (credit_used < UW'(DEPTH));
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A response arriving with a redirect, or while stale requests remain, is thrown away.
  assign rsp_drop = redirect_valid || (drop_cnt_q != '0);
  assign pf_push  = mem_rsp_valid && !rsp_drop;
  assign id_valid = !pf_empty;
  assign pf_pop   = id_valid && id_ready;
  assign {id_pc, id_instr} = pf_head;

  assign unused_flags = pf_full ^ rq_full;

  // PC of each accepted request; its occupancy is the outstanding-request count.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_req_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (mem_rsp_valid),
    .head_data (rsp_pc),
    .count     (outstanding),
    .full      (rq_full),
    .empty     (rq_empty)
  );

  // Prefetch buffer of {pc, instr} presented to decode.
  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_pf_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (pf_push),
    .push_data ({rsp_pc, mem_rsp_data}),
    .pop       (pf_pop),
    .head_data (pf_head),
    .count     (pf_count),
    .full      (pf_full),
    .empty     (pf_empty)
  );

  // Next fetch PC and stale-response counter; a redirect marks everything still in flight as stale.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    started_d  = 1'b1;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      drop_cnt_d = outstanding - CW'(mem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
      if (mem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // Control registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
      started_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
      started_q  <= started_d;
    end
  end

  // A response with no recorded request means the memory and this unit have lost step.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(mem_rsp_valid && rq_empty));
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: a cycle table for the stall
// case, directed redirect/wrap/reset sequences and a randomized phase, all
// scored against a queue-based reference model.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH   = 4;
  localparam int          PC_STEP = 4;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid, id_ready = 1'b0;
  logic [31:0] id_pc, id_instr;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(DEPTH), .PC_STEP(PC_STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr)
  );

  typedef struct { logic [31:0] pc; bit stale; } flight_t;
  typedef struct { logic [31:0] addr; int due; } mrsp_t;
  typedef struct { bit id_ready; bit rv; logic [31:0] addr; bit iv; logic [31:0] ipc; } vec_t;

  fetch_entry_t m_fifo[$];
  flight_t      m_flight[$];
  mrsp_t        mem_q[$];
  logic [31:0]  m_fetch_pc = RST_PC;
  bit           m_started = 0;
  int           cyc = 0, lat = 1, last_due = 0;
  int           n_checks = 0, n_fail = 0;
  bit           drv_redirect = 0, drv_id_ready = 0, drv_mem_ready = 1;
  logic [31:0]  drv_redirect_pc = '0;
  logic         s_req_valid, s_id_valid;
  logic [31:0]  s_req_addr, s_id_pc;
  vec_t         tbl[15];

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive at negedge, score just after, advance models at posedge.
  task automatic cycle();
    bit          exp_rv, fire, pop, rsp, have_f, dut_fire;
    logic [31:0] dut_addr;
    flight_t     f;
    @(negedge clk);
    redirect_valid = drv_redirect;
    redirect_pc    = drv_redirect_pc;
    id_ready       = drv_id_ready;
    mem_req_ready  = drv_mem_ready;
    rsp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    mem_rsp_valid  = rsp;
    mem_rsp_data   = rsp ? instr_of(mem_q[0].addr) : 32'h0;
    #1;
    s_req_valid = mem_req_valid; s_req_addr = mem_req_addr;
    s_id_valid  = id_valid;      s_id_pc    = id_pc;
    exp_rv = m_started && !drv_redirect && ((m_fifo.size() + m_flight.size()) < DEPTH);
    check("mem_req_valid", 32'(mem_req_valid), 32'(exp_rv));
    check("mem_req_addr", mem_req_addr, m_fetch_pc);
    check("id_valid", 32'(id_valid), 32'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) begin
      check("id_pc", id_pc, m_fifo[0].pc);
      check("id_instr", id_instr, m_fifo[0].instr);
    end
    fire     = exp_rv && drv_mem_ready;
    pop      = (m_fifo.size() > 0) && drv_id_ready;
    dut_fire = mem_req_valid && mem_req_ready;
    dut_addr = mem_req_addr;
    @(posedge clk);
    have_f = 0;
    if (rsp) begin
      void'(mem_q.pop_front());
      if (m_flight.size() > 0) begin f = m_flight.pop_front(); have_f = 1; end
    end
    if (dut_fire) begin
      last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mem_q.push_back('{addr: dut_addr, due: last_due});
    end
    if (drv_redirect) begin
      m_fifo.delete();
      foreach (m_flight[i]) m_flight[i].stale = 1;
      m_fetch_pc = drv_redirect_pc - (drv_redirect_pc % PC_STEP);
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (have_f && !f.stale) m_fifo.push_back('{pc: f.pc, instr: instr_of(f.pc)});
      if (fire) begin
        m_flight.push_back('{pc: m_fetch_pc, stale: 0});
        m_fetch_pc = m_fetch_pc + PC_STEP;
      end
    end
    m_started = 1;
    cyc++;
  endtask

  task automatic wait_id(int budget);
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (s_id_valid) return;
    end
    check("id_valid_timeout", 32'(s_id_valid), 32'd1);
  endtask

  task automatic redirect(logic [31:0] pc);
    drv_redirect = 1; drv_redirect_pc = pc;
    cycle();
    drv_redirect = 0;
  endtask

  task automatic clear_models();
    mem_q.delete(); m_flight.delete(); m_fifo.delete();
    m_fetch_pc = RST_PC; m_started = 0; last_due = 0;
  endtask

  initial begin
    int guard;
    tbl[0]  = '{0, 1, 32'h00, 0, 32'h0};
    tbl[1]  = '{0, 1, 32'h04, 0, 32'h0};
    tbl[2]  = '{0, 1, 32'h08, 1, 32'h0};
    tbl[3]  = '{0, 1, 32'h0C, 1, 32'h0};
    for (int i = 4; i < 10; i++) tbl[i] = '{0, 0, 32'h10, 1, 32'h0};
    tbl[10] = '{1, 0, 32'h10, 1, 32'h0};
    tbl[11] = '{1, 1, 32'h10, 1, 32'h4};
    tbl[12] = '{1, 1, 32'h14, 1, 32'h8};
    tbl[13] = '{1, 1, 32'h18, 1, 32'hC};
    tbl[14] = '{1, 1, 32'h1C, 1, 32'h10};

    #2;
    check("reset_req_valid", 32'(mem_req_valid), 32'd0);
    check("reset_id_valid", 32'(id_valid), 32'd0);
    check("reset_id_pc", id_pc, 32'd0);
    check("reset_id_instr", id_instr, 32'd0);
    @(posedge clk); #2 rst_n = 1;
    cycle();

    // Decode stalled for 10 cycles, then released.
    for (int i = 0; i < 15; i++) begin
      drv_id_ready = tbl[i].id_ready;
      cycle();
      check($sformatf("tbl%0d_req_valid", i), 32'(s_req_valid), 32'(tbl[i].rv));
      check($sformatf("tbl%0d_req_addr", i), s_req_addr, tbl[i].addr);
      check($sformatf("tbl%0d_id_valid", i), 32'(s_id_valid), 32'(tbl[i].iv));
      if (tbl[i].iv) check($sformatf("tbl%0d_id_pc", i), s_id_pc, tbl[i].ipc);
    end
    repeat (10) cycle();

    // Misaligned redirect in a cycle with both a pop and an arriving response.
    guard = 0;
    while (!(m_fifo.size() > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc) && guard < 20) begin
      cycle(); guard++;
    end
    redirect(32'h0000_0103);
    cycle();
    check("flush_id_valid", 32'(s_id_valid), 32'd0);
    check("align_req_valid", 32'(s_req_valid), 32'd1);
    check("align_req_addr", s_req_addr, 32'h0000_0100);
    wait_id(20);
    check("align_first_pc", s_id_pc, 32'h0000_0100);

    // Three-cycle memory, three requests in flight, redirect to 0x100.
    lat = 3;
    guard = 0;
    while (m_flight.size() != 3 && guard < 30) begin cycle(); guard++; end
    check("inflight_three", m_flight.size(), 32'd3);
    redirect(32'h0000_0100);
    wait_id(30);
    check("stale_drop_pc0", s_id_pc, 32'h0000_0100);
    cycle();
    check("stale_drop_pc1_valid", 32'(s_id_valid), 32'd1);
    check("stale_drop_pc1", s_id_pc, 32'h0000_0104);

    // Back-to-back redirects: the second one wins.
    lat = 2;
    redirect(32'h0000_0200);
    redirect(32'h0000_0300);
    wait_id(30);
    check("b2b_redirect_pc", s_id_pc, 32'h0000_0300);

    // Sequential fetch wraps past the top of the address space.
    lat = 1;
    redirect(32'hFFFF_FFFC);
    cycle();
    check("wrap_req_addr0", s_req_addr, 32'hFFFF_FFFC);
    cycle();
    check("wrap_req_addr1", s_req_addr, 32'h0000_0000);

    // Randomized traffic scored by the model.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      drv_id_ready    = ($urandom_range(0, 3) != 0);
      drv_mem_ready   = ($urandom_range(0, 3) != 0);
      drv_redirect    = ($urandom_range(0, 19) == 0);
      drv_redirect_pc = $urandom;
      cycle();
    end
    drv_redirect = 0; drv_id_ready = 1; drv_mem_ready = 1; lat = 1;
    repeat (8) cycle();

    // Asynchronous reset between edges, memory reset alongside.
    #3 rst_n = 0;
    #1;
    check("async_id_valid", 32'(id_valid), 32'd0);
    check("async_req_valid", 32'(mem_req_valid), 32'd0);
    redirect_valid = 0; mem_rsp_valid = 0;
    clear_models();
    repeat (3) @(posedge clk);
    check("async_id_pc", id_pc, 32'd0);
    #2 rst_n = 1;
    cycle();
    cycle();
    check("restart_req_valid", 32'(s_req_valid), 32'd1);
    check("restart_req_addr", s_req_addr, RST_PC);
    wait_id(10);
    check("restart_id_pc", s_id_pc, RST_PC);
    repeat (5) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
